// File: rtl/bram_dp_gen.sv
// bram_dp_gen: single-clock true-dual-port block RAM.
// It provides per-lane write enables, a selectable same-port read-during-write
// mode, read-valid strobes, same-address collision reporting and a hardware
// clear sequence after reset.
// Optional macro BRAM_DP_OUTREG_EN adds a second output register stage,
// which gives a read latency of 2 cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | zeroing word[cnt] each cycle; both ports ignored, outputs at 0
// READY | clear finished; both ports accept accesses at full rate
module bram_dp_gen #(
    parameter int DATA_WIDTH     = 72,
    parameter int ADDR_WIDTH     = 6,
    parameter int DEPTH          = 64,
    parameter int LANE_WIDTH     = 9,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dina,
    output logic [DATA_WIDTH-1:0]            douta,
    output logic                             douta_vld,
    input  logic                             enb,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] web,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    input  logic [DATA_WIDTH-1:0]            dinb,
    output logic [DATA_WIDTH-1:0]            doutb,
    output logic                             doutb_vld,
    output logic                             init_done,
    output logic                             collision
);

    localparam int NL = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic                    clr_we;
    logic                    ready;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ina, inb, same;
    logic                    wr_a, wr_b;
    logic                    we_a, we_b;
    logic [DATA_WIDTH-1:0]   rd_a, rd_b;
    logic [DATA_WIDTH-1:0]   own_a, own_b;
    logic [DATA_WIDTH-1:0]   new_a;

    logic [DATA_WIDTH-1:0]   douta_s1, doutb_s1;
    logic                    vlda_s1, vldb_s1, coll_s1;

    // Overlay the enabled lanes of din onto base.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] din,
        input logic [NL-1:0]         we
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int i = 0; i < NL; i++) begin
            if (we[i]) begin
                r[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return r;
    endfunction

    // Register the state and clear counter; reset restarts the clear at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Step the clear sequence and leave CLEAR after the last word is zeroed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST_ADDR) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    assign ready     = (state == READY);
    assign init_done = ready;

    // Decode the access: range checks, old contents and the words to be written.
    // On a both-write to one address, B's lanes are laid down first and A's
    // lanes on top, so A wins wherever both ports write the same lane.
    always_comb begin
        ina   = ({1'b0, addra} < DEPTH_W);
        inb   = ({1'b0, addrb} < DEPTH_W);
        same  = (addra == addrb);
        wr_a  = |wea;
        wr_b  = |web;
        we_a  = ready && ena && wr_a && ina;
        we_b  = ready && enb && wr_b && inb;
        rd_a  = ina ? mem[addra] : '0;
        rd_b  = inb ? mem[addrb] : '0;
        own_a = ina ? lane_merge(rd_a, dina, wea) : '0;
        own_b = inb ? lane_merge(rd_b, dinb, web) : '0;
        new_a = (we_b && same) ? lane_merge(own_b, dina, wea) : own_a;
    end

    // Array writes: clear has priority; port A is written last so it wins on overlap.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else begin
            if (we_b) mem[addrb] <= own_b;
            if (we_a) mem[addra] <= new_a;
        end
    end

    // First output stage: read data, valid strobes and the collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta_s1 <= '0;
            doutb_s1 <= '0;
            vlda_s1  <= 1'b0;
            vldb_s1  <= 1'b0;
            coll_s1  <= 1'b0;
        end else if (!ready) begin
            douta_s1 <= '0;
            doutb_s1 <= '0;
            vlda_s1  <= 1'b0;
            vldb_s1  <= 1'b0;
            coll_s1  <= 1'b0;
        end else begin
            coll_s1 <= ena && enb && same && (wr_a || wr_b);

            vlda_s1 <= 1'b0;
            if (ena && !(wr_a && RDW_MODE == 2)) begin
                vlda_s1  <= 1'b1;
                douta_s1 <= (wr_a && RDW_MODE == 1) ? own_a : rd_a;
            end

            vldb_s1 <= 1'b0;
            if (enb && !(wr_b && RDW_MODE == 2)) begin
                vldb_s1  <= 1'b1;
                doutb_s1 <= (wr_b && RDW_MODE == 1) ? own_b : rd_b;
            end
        end
    end

`ifdef BRAM_DP_OUTREG_EN
    logic [DATA_WIDTH-1:0] douta_s2, doutb_s2;
    logic                  vlda_s2, vldb_s2, coll_s2;

    // Second output stage; held at 0 while clearing like the first stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta_s2 <= '0;
            doutb_s2 <= '0;
            vlda_s2  <= 1'b0;
            vldb_s2  <= 1'b0;
            coll_s2  <= 1'b0;
        end else if (!ready) begin
            douta_s2 <= '0;
            doutb_s2 <= '0;
            vlda_s2  <= 1'b0;
            vldb_s2  <= 1'b0;
            coll_s2  <= 1'b0;
        end else begin
            douta_s2 <= douta_s1;
            doutb_s2 <= doutb_s1;
            vlda_s2  <= vlda_s1;
            vldb_s2  <= vldb_s1;
            coll_s2  <= coll_s1;
        end
    end

    assign douta     = douta_s2;
    assign doutb     = doutb_s2;
    assign douta_vld = vlda_s2;
    assign doutb_vld = vldb_s2;
    assign collision = coll_s2;
`else
    assign douta     = douta_s1;
    assign doutb     = doutb_s1;
    assign douta_vld = vlda_s1;
    assign doutb_vld = vldb_s1;
    assign collision = coll_s1;
`endif

endmodule
